// File: rtl/levinson_seq.sv
`timescale 1ns/1ps
// levinson_seq: sequencer for the Levinson-Durbin recursion of the LPC core.
// Reads autocorrelation lags from a synchronous RAM, accumulates q for each
// order with an internal MAC, hands q/e to the shared divider (k = -q/e), and
// updates the predictor coefficients a(0..P) and the prediction error e.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, order          run request (sampled in IDLE) and predictor order P
//   busy, done, err       run in progress, completion pulse, sticky error
//   r_addr, r_rd, r_data  lag RAM read port (data one cycle after r_rd)
//   div_q, div_e, div_k   shared reflection-coefficient divider interface
//   k_valid, k_data       one strobe per reflection coefficient k(i)
//   coef_addr, coef_data  combinational readback of a(coef_addr)
//   e_out                 final prediction error
module levinson_seq #(
   parameter int ORDER_MAX = 16,
   parameter int DIV_LAT   = 0,
   parameter int AW        = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] order,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW-1:0] r_addr,
   output logic          r_rd,
   input  logic [31:0]   r_data,
   output logic [31:0]   div_q,
   output logic [31:0]   div_e,
   input  logic [31:0]   div_k,
   output logic          k_valid,
   output logic [31:0]   k_data,
   input  logic [AW-1:0] coef_addr,
   output logic [31:0]   coef_data,
   output logic [31:0]   e_out
);
   localparam int DW = (DIV_LAT > 0) ? $clog2(DIV_LAT + 1) : 1;
   localparam logic [AW-1:0] A_ONE = AW'(1'b1);
   localparam logic [AW-1:0] A_MAX = AW'(ORDER_MAX);
   localparam logic [DW-1:0] D_ONE = DW'(1'b1);
   localparam logic [DW-1:0] D_LAT = DW'(DIV_LAT);
   localparam logic [31:0] K_MIN = 32'h8000_0000;
   localparam logic signed [31:0] A_UNITY = 32'sh0800_0000;

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_MAC, S_DIV, S_UPD, S_FIN} state_t;
   state_t state_r, state_s;

   logic [AW-1:0]        order_r, i_r, cnt_r;
   logic [DW-1:0]        div_cnt_r;
   logic signed [31:0]   a_r [0:ORDER_MAX];
   logic [31:0]          e_r;
   logic signed [31:0]   k_r;
   logic signed [71:0]   acc_r;

   logic                 bad_order_s, upd_final_s;
   logic [AW-1:0]        j_mac_s, j_hi_s;
   logic signed [63:0]   prod_s, p1_s, p2_s, ksq_s;
   logic signed [71:0]   acc_next_s;
   logic [31:0]          q_s, e_new_s, dec_s;
   logic [63:0]          ekk_s;
   logic signed [31:0]   upd_lo_s, upd_hi_s;
   logic                 unused_bits_s;

   assign coef_data = (coef_addr <= A_MAX) ? a_r[coef_addr] : 32'd0;
   assign unused_bits_s = ^{p1_s[63], p1_s[30:0], p2_s[63], p2_s[30:0],
                            ksq_s[63], ksq_s[30:0], ekk_s[63], ekk_s[30:0]};

   // Datapath arithmetic: MAC product/saturation, pair updates, error update.
   always_comb begin
      bad_order_s = (order == '0) || (order > A_MAX);
      upd_final_s = (cnt_r > (i_r >> 1));
      j_mac_s     = cnt_r - A_ONE;
      j_hi_s      = i_r - cnt_r;
      prod_s      = 64'(a_r[j_mac_s]) * 64'($signed(r_data));
      acc_next_s  = acc_r + {{8{prod_s[63]}}, prod_s};
      // q = sat32(acc >>> 28): in range when bits 71..59 are all equal
      if ((&acc_next_s[71:59]) || !(|acc_next_s[71:59])) begin
         q_s = acc_next_s[59:28];
      end else begin
         q_s = acc_next_s[71] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      p1_s     = 64'(k_r) * 64'(a_r[j_hi_s]);
      p2_s     = 64'(k_r) * 64'(a_r[cnt_r]);
      upd_lo_s = a_r[cnt_r] + p1_s[62:31];
      upd_hi_s = a_r[j_hi_s] + p2_s[62:31];
      // (k*k)>>>31 is non-negative and below 2^31 because k = -1.0 is rejected
      ksq_s    = 64'(k_r) * 64'(k_r);
      ekk_s    = {32'd0, e_r} * {32'd0, ksq_s[62:31]};
      dec_s    = ekk_s[62:31];
      if (dec_s > e_r) begin
         e_new_s = 32'd0;
      end else begin
         e_new_s = e_r - dec_s;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_s = bad_order_s ? S_FIN : S_INIT;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_INIT: begin
            if (cnt_r == A_ONE) begin
               state_s = (r_data == 32'd0) ? S_FIN : S_MAC;
            end else begin
               state_s = S_INIT;
            end
         end
         S_MAC: begin
            if (cnt_r == i_r) begin
               state_s = S_DIV;
            end else begin
               state_s = S_MAC;
            end
         end
         S_DIV: begin
            if (div_cnt_r == D_LAT) begin
               state_s = ((e_r == 32'd0) || (div_k == K_MIN)) ? S_FIN : S_UPD;
            end else begin
               state_s = S_DIV;
            end
         end
         S_UPD: begin
            if (upd_final_s) begin
               state_s = (i_r == order_r) ? S_FIN : S_MAC;
            end else begin
               state_s = S_UPD;
            end
         end
         S_FIN:   state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // Datapath registers and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0; done <= 1'b0; err <= 1'b0; k_valid <= 1'b0; r_rd <= 1'b0;
         r_addr <= '0; div_q <= 32'd0; div_e <= 32'd0; k_data <= 32'd0; e_out <= 32'd0;
         order_r <= '0; i_r <= '0; cnt_r <= '0; div_cnt_r <= '0;
         e_r <= 32'd0; k_r <= 32'sd0; acc_r <= 72'sd0;
         for (int n = 0; n <= ORDER_MAX; n++) a_r[n] <= 32'sd0;
      end else begin
         r_rd    <= 1'b0;
         k_valid <= 1'b0;
         done    <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  order_r <= order;
                  if (bad_order_s) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     e_out <= e_r;
                  end else begin
                     err    <= 1'b0;
                     busy   <= 1'b1;
                     i_r    <= A_ONE;
                     cnt_r  <= '0;
                     r_rd   <= 1'b1;
                     r_addr <= '0;
                     for (int n = 0; n <= ORDER_MAX; n++) a_r[n] <= (n == 0) ? A_UNITY : 32'sd0;
                  end
               end
            end
            S_INIT: begin
               if (cnt_r != A_ONE) begin
                  cnt_r <= A_ONE;
               end else if (r_data == 32'd0) begin
                  err <= 1'b1; done <= 1'b1; busy <= 1'b0; e_out <= e_r;
               end else begin
                  e_r    <= r_data;
                  cnt_r  <= '0;
                  acc_r  <= 72'sd0;
                  r_rd   <= 1'b1;
                  r_addr <= i_r;
               end
            end
            S_MAC: begin
               // cycle c issues the read for j=c and accumulates j=c-1
               if (cnt_r != '0) acc_r <= acc_next_s;
               if ((cnt_r + A_ONE) < i_r) begin
                  r_rd   <= 1'b1;
                  r_addr <= i_r - (cnt_r + A_ONE);
               end
               if (cnt_r == i_r) begin
                  div_q     <= q_s;
                  div_e     <= e_r;
                  div_cnt_r <= '0;
               end else begin
                  cnt_r <= cnt_r + A_ONE;
               end
            end
            S_DIV: begin
               if (div_cnt_r != D_LAT) begin
                  div_cnt_r <= div_cnt_r + D_ONE;
               end else if ((e_r == 32'd0) || (div_k == K_MIN)) begin
                  err <= 1'b1; done <= 1'b1; busy <= 1'b0; e_out <= e_r;
               end else begin
                  k_r     <= div_k;
                  k_data  <= div_k;
                  k_valid <= 1'b1;
                  cnt_r   <= A_ONE;
               end
            end
            S_UPD: begin
               if (!upd_final_s) begin
                  a_r[cnt_r] <= upd_lo_s;
                  if (cnt_r != j_hi_s) a_r[j_hi_s] <= upd_hi_s;
                  cnt_r <= cnt_r + A_ONE;
               end else begin
                  a_r[i_r] <= k_r >>> 4;
                  e_r      <= e_new_s;
                  i_r      <= i_r + A_ONE;
                  if (i_r == order_r) begin
                     done <= 1'b1; busy <= 1'b0; e_out <= e_new_s;
                  end else begin
                     cnt_r  <= '0;
                     acc_r  <= 72'sd0;
                     r_rd   <= 1'b1;
                     r_addr <= i_r + A_ONE;
                  end
               end
            end
            S_FIN:   busy <= 1'b0;
            default: busy <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_levinson_seq.sv
`timescale 1ns/1ps
module tb_levinson_seq;
   logic        clk = 1'b0;
   logic        rst, start, busy, done, err, r_rd, k_valid;
   logic [4:0]  order, r_addr, coef_addr;
   logic [31:0] r_data = 32'd0;
   logic [31:0] div_q, div_e, div_k, k_data, coef_data, e_out;

   always #5 clk = ~clk;

   levinson_seq #(.ORDER_MAX(16), .DIV_LAT(0), .AW(5)) dut (
      .clk(clk), .rst(rst), .start(start), .order(order), .busy(busy), .done(done),
      .err(err), .r_addr(r_addr), .r_rd(r_rd), .r_data(r_data), .div_q(div_q),
      .div_e(div_e), .div_k(div_k), .k_valid(k_valid), .k_data(k_data),
      .coef_addr(coef_addr), .coef_data(coef_data), .e_out(e_out));

   // Divider: k = -q/e, q scale 2^-33, e scale 2^-34, k scale 2^-31; |k|>=1 -> 0x80000000
   function automatic logic [31:0] div_model(input logic [31:0] q, input logic [31:0] e);
      longint num, quo;
      logic [63:0] quo_bits;
      if (e == 32'd0) return 32'h8000_0000;
      num = longint'($signed(q)) <<< 32;
      quo = -(num / longint'({32'd0, e}));
      if (quo >= 64'sd2147483648 || quo < -64'sd2147483648) return 32'h8000_0000;
      quo_bits = quo;
      return quo_bits[31:0];
   endfunction
   assign div_k = div_model(div_q, div_e);

   // Autocorrelation RAM, one-cycle read latency.
   logic [31:0] ram [0:31];
   always @(posedge clk) if (r_rd) r_data <= ram[r_addr];

   int checks = 0, errors = 0;
   logic [4:0]  addr_q [$];
   logic [31:0] k_q [$];
   logic [4:0]  addr_log [$];
   int rd_seen, kv_seen, last_n;
   logic [31:0] last_k;
   bit mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
      end
   endtask

   // Scoreboard: RAM reads and reflection coefficients popped as the DUT emits them.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (r_rd) begin
            rd_seen++;
            addr_log.push_back(r_addr);
            if (addr_q.size() == 0) check("rd_extra", 32'(r_addr), 32'hFFFF_FFFF);
            else check("r_addr", 32'(r_addr), 32'(addr_q.pop_front()));
         end
         if (k_valid) begin
            kv_seen++;
            last_k = k_data;
            if (k_q.size() == 0) check("k_extra", k_data, 32'hFFFF_FFFF);
            else check("k_data", k_data, k_q.pop_front());
         end
      end
   end

   // Reference recursion.
   logic signed [31:0] m_a [0:16];
   logic [31:0] m_e = 32'd0;
   bit m_eknown;

   task automatic model_run(input int p);
      logic signed [71:0] acc, acc_sh;
      logic signed [31:0] q, k, aj, aij;
      logic signed [63:0] pr;
      logic [63:0] ue;
      logic [31:0] kk, d;
      m_eknown = 1'b0;
      if (p == 0 || p > 16) return;
      for (int n = 0; n <= 16; n++) m_a[n] = (n == 0) ? 32'sh0800_0000 : 32'sd0;
      addr_q.push_back(5'd0);
      if (ram[0] == 32'd0) return;
      m_e = ram[0];
      m_eknown = 1'b1;
      for (int i = 1; i <= p; i++) begin
         acc = 72'sd0;
         for (int j = 0; j < i; j++) begin
            addr_q.push_back(5'(i - j));
            pr  = 64'(m_a[j]) * 64'($signed(ram[i - j]));
            acc = acc + 72'(pr);
         end
         acc_sh = acc >>> 28;
         if (acc_sh > 72'sd2147483647) q = 32'sh7FFF_FFFF;
         else if (acc_sh < -72'sd2147483648) q = 32'sh8000_0000;
         else q = acc_sh[31:0];
         k = div_model(q, m_e);
         if (m_e == 32'd0 || k == 32'sh8000_0000) return;
         k_q.push_back(k);
         for (int j = 1; j <= i / 2; j++) begin
            aj = m_a[j];
            aij = m_a[i - j];
            pr = 64'(k) * 64'(aij);
            m_a[j] = aj + 32'(pr >>> 31);
            if (j != i - j) begin
               pr = 64'(k) * 64'(aj);
               m_a[i - j] = aij + 32'(pr >>> 31);
            end
         end
         m_a[i] = k >>> 4;
         pr = 64'(k) * 64'(k);
         kk = 32'(pr >>> 31);
         ue = 64'(m_e) * 64'(kk);
         d  = 32'(ue >> 31);
         m_e = (d > m_e) ? 32'd0 : m_e - d;
      end
   endtask

   typedef struct packed {
      logic [5:0]       p;
      logic [4:0][31:0] r;
      logic             exp_err;
      logic [4:0]       exp_k;
   } vec_t;

   function automatic vec_t mk(input int p, input logic [31:0] r0, input logic [31:0] r1,
                               input logic [31:0] r2, input logic [31:0] r3,
                               input logic [31:0] r4, input logic e, input int k);
      vec_t t;
      t.p = 6'(p);
      t.r[0] = r0; t.r[1] = r1; t.r[2] = r2; t.r[3] = r3; t.r[4] = r4;
      t.exp_err = e;
      t.exp_k = 5'(k);
      return t;
   endfunction

   task automatic load_ram(input vec_t v);
      for (int a = 0; a < 32; a++) ram[a] = 32'd0;
      for (int a = 0; a < 5; a++) ram[a] = v.r[a];
   endtask

   task automatic run_case(input vec_t v, input bit inject);
      int n, nexp_rd;
      bit valid_p;
      valid_p = (v.p != 6'd0) && (v.p <= 6'd16);
      load_ram(v);
      addr_log.delete();
      rd_seen = 0;
      kv_seen = 0;
      model_run(int'(v.p));
      nexp_rd = addr_q.size();
      mon_en = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      order = v.p[4:0];
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      check("busy_first", 32'(busy), 32'(valid_p));
      while (done !== 1'b1 && n < 300) begin
         if (inject && n == 3) begin
            start = 1'b1;
            order = 5'd1;
         end else begin
            start = 1'b0;
            order = v.p[4:0];
         end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      last_n = n;
      check("done_seen", 32'(done), 32'd1);
      check("err", 32'(err), 32'(v.exp_err));
      check("busy_at_done", 32'(busy), 32'd0);
      if (!valid_p) check("bad_p_lat", 32'(n), 32'd1);
      @(posedge clk); #1;
      check("done_pulse", 32'(done), 32'd0);
      check("rd_count", 32'(rd_seen), 32'(nexp_rd));
      check("kv_count", 32'(kv_seen), 32'(v.exp_k));
      check("k_left", 32'(k_q.size()), 32'd0);
      check("rd_left", 32'(addr_q.size()), 32'd0);
      if (m_eknown) check("e_out", e_out, m_e);
      for (int c = 0; c <= 4; c++) begin
         coef_addr = 5'(c);
         #1;
         check("coef", coef_data, m_a[c]);
      end
      mon_en = 1'b0;
      k_q.delete();
      addr_q.delete();
   endtask

   vec_t vecs [0:6];
   logic [4:0] seq_p2 [0:3];

   initial begin
      vecs[0] = mk(1,  32'h4000_0000, 32'h2000_0000, 32'd0, 32'd0, 32'd0, 1'b0, 1);
      vecs[1] = mk(2,  32'h4000_0000, 32'h2000_0000, 32'd0, 32'd0, 32'd0, 1'b0, 2);
      vecs[2] = mk(3,  32'd0,         32'h2000_0000, 32'd0, 32'd0, 32'd0, 1'b1, 0);
      vecs[3] = mk(2,  32'h4000_0000, 32'h4000_0000, 32'd0, 32'd0, 32'd0, 1'b1, 0);
      vecs[4] = mk(0,  32'h4000_0000, 32'h2000_0000, 32'd0, 32'd0, 32'd0, 1'b1, 0);
      vecs[5] = mk(17, 32'h4000_0000, 32'h2000_0000, 32'd0, 32'd0, 32'd0, 1'b1, 0);
      vecs[6] = mk(4,  32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000,
                   32'h0800_0000, 1'b0, 4);
      seq_p2 = '{5'd0, 5'd1, 5'd2, 5'd1};

      rst = 1'b1; start = 1'b0; order = 5'd0; coef_addr = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_kvalid", 32'(k_valid), 32'd0);
      check("rst_rrd", 32'(r_rd), 32'd0);
      check("rst_eout", e_out, 32'd0);
      check("rst_divq", div_q, 32'd0);
      check("rst_kdata", k_data, 32'd0);
      check("rst_a0", coef_data, 32'd0);
      rst = 1'b0;

      // Reset in the middle of MAC for P=4.
      load_ram(vecs[6]);
      @(posedge clk); #1;
      start = 1'b1; order = 5'd4;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_done", 32'(done), 32'd0);
      check("mid_kvalid", 32'(k_valid), 32'd0);
      check("mid_a0", coef_data, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         run_case(vecs[v], v == 6);
         if (v == 0) begin
            check("p1_k", last_k, 32'hC000_0000);
            coef_addr = 5'd1;
            #1;
            check("p1_a1", coef_data, 32'hFC00_0000);
            check("p1_eout", e_out, 32'h3000_0000);
            check("p1_latency", 32'(last_n <= 12), 32'd1);
         end
         if (v == 1) begin
            check("p2_nrd", 32'(addr_log.size()), 32'd4);
            for (int s = 0; s < 4 && s < addr_log.size(); s++)
               check("p2_seq", 32'(addr_log[s]), 32'(seq_p2[s]));
         end
         if (v == 3) check("sat_eout", e_out, 32'h4000_0000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
